// File: rtl/alu_mdu_pkg.sv
// Shared types and constants for the EX-stage ALU control decoder and the
// iterative RV32M/RV64M multiply/divide unit.
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_BR  = 4'b1000,
    OP_SRA = 4'b1010,
    OP_SLT = 4'b1100,
    OP_MDU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ZERO  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // rs1 is signed for MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // rs2 is signed for MULH, DIV, REM
  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, one radix-2 step per cycle, sign correction on the last step.
module md_datapath
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] srca_i,
  input  logic [XLEN-1:0] srcb_i,
  output logic            last_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d, nega_q, nega_d;

  logic            a_neg_c, b_neg_c;
  logic [XLEN:0]   mul_sum_c, div_sh_c, div_diff_c;
  logic [2*XLEN-1:0] prod_c, prod_s_c;
  logic [XLEN-1:0] quo_s_c, rem_s_c;

  assign a_neg_c = rs1_signed(funct3_i) & srca_i[XLEN-1];
  assign b_neg_c = rs2_signed(funct3_i) & srcb_i[XLEN-1];
  assign last_c  = step_i && (cnt_q == CW'(XLEN - 1));

  // hi/lo hold {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    nega_d     = nega_q;
    mul_sum_c  = '0;
    div_sh_c   = '0;
    div_diff_c = '0;
    if (start_i) begin
      hi_d   = '0;
      lo_d   = a_neg_c ? -srca_i : srca_i;
      opb_d  = b_neg_c ? -srcb_i : srcb_i;
      cnt_d  = '0;
      f3_d   = funct3_i;
      neg_d  = a_neg_c ^ b_neg_c;
      nega_d = a_neg_c;
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (!f3_q[2]) begin
        mul_sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        {hi_d, lo_d} = {mul_sum_c, lo_q[XLEN-1:1]};
      end else begin
        div_sh_c   = {hi_q, lo_q[XLEN-1]};
        div_diff_c = div_sh_c - {1'b0, opb_q};
        if (!div_diff_c[XLEN]) begin
          hi_d = div_diff_c[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_sh_c[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Sign-corrected result from the post-step values, captured by the controller on the last step
  always_comb begin
    prod_c   = {hi_d, lo_d};
    prod_s_c = neg_q ? -prod_c : prod_c;
    quo_s_c  = neg_q ? -lo_d : lo_d;
    rem_s_c  = nega_q ? -hi_d : hi_d;
    if (!f3_q[2]) begin
      result_c = (f3_q[1:0] == 2'b00) ? prod_s_c[XLEN-1:0] : prod_s_c[2*XLEN-1:XLEN];
    end else begin
      result_c = f3_q[1] ? rem_s_c : quo_s_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      nega_q <= nega_d;
    end
  end

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU control decode plus FSM sequencing the iterative M-extension unit,
// with pipeline stall, done pulse and held result for the EX result mux.
module alu_mdu_controller
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN - 1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic            md_done_q, md_done_d;

  alu_op_e         op_c;
  logic            is_mop_c, accept_c, busy_c, last_c;
  logic            div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0] special_res_c, result_c;

  assign is_mop_c   = ENABLE_M && (ALUOp == ALUOP_RTYPE) && (Funct7 == F7_MULDIV);
  assign accept_c   = in_valid && is_mop_c && !flush && !reset && (state_q == IDLE);
  assign busy_c     = (state_q == MUL) || (state_q == DIV);
  assign div_zero_c = (SrcB == '0);
  assign div_ovf_c  = !Funct3[0] && (SrcA == INT_MIN) && (&SrcB);
  assign special_c  = Funct3[2] && (div_zero_c || div_ovf_c);

  // Divide-by-zero and signed overflow bypass the iteration entirely
  always_comb begin
    if (div_zero_c) begin
      special_res_c = Funct3[1] ? SrcA : '1;
    end else begin
      special_res_c = Funct3[1] ? '0 : SrcA;
    end
  end

  always_comb begin
    op_c = OP_ADD;
    case (ALUOp)
      ALUOP_ADD:  op_c = OP_ADD;
      ALUOP_BR:   op_c = OP_BR;
      ALUOP_ZERO: op_c = OP_AND;
      default: begin
        if (is_mop_c) begin
          op_c = OP_MDU;
        end else begin
          case (Funct3)
            3'b000:  op_c = (Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  op_c = OP_SLL;
            3'b010:  op_c = OP_SLT;
            3'b100:  op_c = OP_XOR;
            3'b101:  op_c = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  op_c = OP_OR;
            3'b111:  op_c = OP_AND;
            default: op_c = OP_ADD;
          endcase
        end
      end
    endcase
  end

  md_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept_c),
    .step_i   (busy_c),
    .funct3_i (Funct3),
    .srca_i   (SrcA),
    .srcb_i   (SrcB),
    .last_c   (last_c),
    .result_c (result_c)
  );

  always_comb begin
    state_d     = state_q;
    md_result_d = md_result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (special_c) begin
              state_d     = DONE;
              md_result_d = special_res_c;
            end else begin
              state_d = Funct3[2] ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          if (last_c) begin
            state_d     = DONE;
            md_result_d = result_c;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    md_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      md_result_q <= '0;
      md_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_result_q <= md_result_d;
      md_done_q   <= md_done_d;
    end
  end

  assign Operation = op_c;
  assign md_stall  = accept_c || busy_c;
  assign md_done   = md_done_q;
  assign md_result = md_result_q;

endmodule
